// File: rtl/toggle_pkg.sv
// toggle_pkg: shared constants for the toggle counter.
//   DEFAULT_WIDTH : default counter width in bits
//   DIR_UP/DIR_DN : values of the 'up' direction input
package toggle_pkg;
    localparam int   DEFAULT_WIDTH = 4;
    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DN        = 1'b0;
endpackage : toggle_pkg

// File: rtl/t_flip_cell.sv
// t_flip_cell: one-bit T flip-flop storage cell.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset, clears q
//   t   : toggle request; q inverts on the edge when t=1
//   q   : stored bit
module t_flip_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule : t_flip_cell

// File: rtl/toggle_counter.sv
// toggle_counter: modulo (0..mod_max) up/down counter built from T cells.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset (q=0, ovf=0, t=0, tc=0)
//   en      : count one step this clock
//   up      : direction, DIR_UP counts up, DIR_DN counts down
//   load    : synchronous load of din (clamped to mod_max), beats en
//   din     : load value
//   mod_max : terminal value of the count range
//   clr_ovf : synchronous clear of ovf (a wrap in the same cycle wins)
//   q       : registered count
//   t       : per-bit toggle vector, q_next ^ q
//   tc      : combinational terminal count (a wrap happens on this edge)
//   ovf     : sticky wrap flag
module toggle_counter
    import toggle_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] mod_max,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_next;
    logic             wrap;

    // Next-state selection; the count itself only moves through toggles.
    always_comb begin
        q_next = q;
        wrap   = 1'b0;
        if (load) begin
            q_next = (din > mod_max) ? mod_max : din;
        end else if (en) begin
            if (up == DIR_UP) begin
                // q above a shrunken mod_max also wraps to 0.
                if (q >= mod_max) begin
                    q_next = '0;
                    wrap   = 1'b1;
                end else begin
                    q_next = q + ONE;
                end
            end else begin
                if (q == '0) begin
                    q_next = mod_max;
                    wrap   = 1'b1;
                end else if (q > mod_max) begin
                    // Re-range into 0..mod_max; not counted as a wrap.
                    q_next = mod_max;
                end else begin
                    q_next = q - ONE;
                end
            end
        end
    end

    // Gating with rst keeps t and tc at 0 during reset regardless of inputs.
    assign t  = rst ? (q_next ^ q) : '0;
    assign tc = rst & wrap;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_flip_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t[i]),
            .q   (q[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (wrap) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule : toggle_counter

// File: tb/tb_toggle_counter.sv
// tb_toggle_counter: directed and randomized bench for toggle_counter.
module tb_toggle_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] mod_max = '0;
    logic         clr_ovf = 1'b0;
    logic [W-1:0] q;
    logic [W-1:0] t;
    logic         tc;
    logic         ovf;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference state kept as plain integers.
    int           mq   = 0;
    int           movf = 0;
    logic [W-1:0] exp_q[$];

    toggle_counter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .load    (load),
        .din     (din),
        .mod_max (mod_max),
        .clr_ovf (clr_ovf),
        .q       (q),
        .t       (t),
        .tc      (tc),
        .ovf     (ovf)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural next count, straight from the counting rules.
    function automatic int ref_next(int cq, int e, int u, int l, int d, int m);
        if (l != 0) return (d > m) ? m : d;
        if (e == 0) return cq;
        if (u != 0) return (cq + 1 > m) ? 0 : cq + 1;
        if (cq == 0 || cq > m) return m;
        return cq - 1;
    endfunction

    function automatic int ref_wrap(int cq, int e, int u, int l, int m);
        if (l != 0 || e == 0) return 0;
        if (u != 0) return (cq >= m) ? 1 : 0;
        return (cq == 0) ? 1 : 0;
    endfunction

    // Driver: one clock with the given inputs; checks t/tc before the edge
    // and q/ovf after it.
    task automatic cycle(input logic e, input logic u, input logic l,
                         input logic [W-1:0] d, input logic [W-1:0] m, input logic c);
        int nq;
        int wr;
        logic [W-1:0] cur;
        logic [W-1:0] nxt;
        logic [W-1:0] eq;
        @(negedge clk);
        en = e; up = u; load = l; din = d; mod_max = m; clr_ovf = c;
        #1;
        nq  = ref_next(mq, int'(e), int'(u), int'(l), int'(d), int'(m));
        wr  = ref_wrap(mq, int'(e), int'(u), int'(l), int'(m));
        cur = W'(mq);
        nxt = W'(nq);
        check("tc", 16'(tc), 16'(wr));
        check("t", 16'(t), 16'(nxt ^ cur));
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        mq = nq;
        if (wr != 0) movf = 1;
        else if (c) movf = 0;
        eq = exp_q.pop_front();
        check("q", 16'(q), 16'(eq));
        check("ovf", 16'(ovf), 16'(movf));
    endtask

    // Assert reset between edges, check the immediate effect, hold for n edges.
    task automatic do_reset(input int n);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        mq = 0; movf = 0;
        check("rst_q", 16'(q), 16'(0));
        check("rst_ovf", 16'(ovf), 16'(0));
        en = 1'b1; load = 1'b1; din = 4'd5; clr_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_q", 16'(q), 16'(0));
            check("rst_hold_ovf", 16'(ovf), 16'(0));
            check("rst_hold_t", 16'(t), 16'(0));
            check("rst_hold_tc", 16'(tc), 16'(0));
        end
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0; load = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rmm;
        // Reset state with active-looking inputs.
        en = 1'b1; load = 1'b0; mod_max = 4'd9;
        #12;
        check("init_q", 16'(q), 16'(0));
        check("init_ovf", 16'(ovf), 16'(0));
        check("init_t", 16'(t), 16'(0));
        check("init_tc", 16'(tc), 16'(0));
        @(negedge clk);
        rst = 1'b1; en = 1'b0;

        // Up wrap at 9: expect tc before the edge, then q=0, ovf=1, t=1001.
        cycle(1'b0, 1'b1, 1'b1, 4'd9, 4'd9, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0);
        check("upwrap_q", 16'(q), 16'(0));
        check("upwrap_ovf", 16'(ovf), 16'(1));

        // Down wrap from 0 to 9, then 8.
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0);
        check("dnwrap_q", 16'(q), 16'(9));
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0);
        check("dnstep_q", 16'(q), 16'(8));

        // Load clamp and load-over-enable priority.
        cycle(1'b1, 1'b1, 1'b1, 4'd12, 4'd9, 1'b0);
        check("clamp_q", 16'(q), 16'(9));
        cycle(1'b1, 1'b1, 1'b1, 4'd3, 4'd9, 1'b0);
        check("load3_q", 16'(q), 16'(3));

        // clr_ovf alone clears; clr_ovf with a wrap leaves ovf set.
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1);
        check("clr_ovf", 16'(ovf), 16'(0));
        cycle(1'b0, 1'b1, 1'b1, 4'd9, 4'd9, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 4'd9, 4'd9, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1);
        check("clr_vs_wrap", 16'(ovf), 16'(1));

        // Shrinking mod_max from above the count.
        cycle(1'b0, 1'b1, 1'b1, 4'd7, 4'd9, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 1'b0);
        check("shrink_up_q", 16'(q), 16'(0));
        cycle(1'b0, 1'b1, 1'b1, 4'd7, 4'd9, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0);
        check("shrink_dn_q", 16'(q), 16'(4));

        // mod_max == 0: count pinned at 0, tc on every enabled step.
        cycle(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, logic'(i % 2), 1'b0, 4'd0, 4'd0, 1'b0);

        // Reset mid-count: load 0, five up steps, then reset between edges.
        cycle(1'b0, 1'b1, 1'b1, 4'd0, 4'd9, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0);
        check("midcount_q", 16'(q), 16'(5));
        do_reset(2);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0);
        check("after_rst_q", 16'(q), 16'(1));

        // Randomized traffic.
        rmm = 4'd9;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) rmm = W'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) begin
                do_reset(1);
            end else begin
                cycle(logic'($urandom_range(0, 3) != 0),
                      logic'($urandom_range(0, 1)),
                      logic'($urandom_range(0, 7) == 0),
                      W'($urandom_range(0, 15)),
                      rmm,
                      logic'($urandom_range(0, 7) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_toggle_counter
